// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding and width constants.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    // rem < divisor always holds, so the extra top bit of diff is exactly the borrow.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor_mag};
    assign borrow   = diff[WIDTH];
    assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider sequencer: quotient on lo, remainder on hi, start/done handshake.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dividend_reg, divisor_reg;
    logic             sgn_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, dmag_reg;
    logic             q_neg_reg, r_neg_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic             dividend_neg, divisor_neg;

    assign dividend_neg = sgn_reg & dividend_reg[WIDTH-1];
    assign divisor_neg  = sgn_reg & divisor_reg[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_reg),
        .quo         (quo_reg),
        .divisor_mag (dmag_reg),
        .rem_next    (rem_next),
        .quo_next    (quo_next)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_PREP;
            S_PREP:  state_next = (divisor_reg == '0) ? S_DONE : S_ITER;
            S_ITER:  if (count_reg == '0) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg    <= S_IDLE;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            sgn_reg      <= 1'b0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dmag_reg     <= '0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            count_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            dbz_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        dividend_reg <= dividend;
                        divisor_reg  <= divisor;
                        sgn_reg      <= signed_op;
                        dbz_reg      <= 1'b0;
                    end
                end
                S_PREP: begin
                    quo_reg   <= dividend_neg ? -dividend_reg : dividend_reg;
                    dmag_reg  <= divisor_neg ? -divisor_reg : divisor_reg;
                    q_neg_reg <= dividend_neg ^ divisor_neg;
                    r_neg_reg <= dividend_neg;
                    rem_reg   <= '0;
                    count_reg <= CW'(WIDTH - 1);
                    if (divisor_reg == '0) begin
                        dbz_reg <= 1'b1;
                        lo_reg  <= {WIDTH{1'b1}};
                        hi_reg  <= dividend_reg;
                    end
                end
                S_ITER: begin
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_reg - 1'b1;
                end
                S_FIX: begin
                    // Remainder takes the dividend's sign, so the quotient truncates toward zero.
                    lo_reg <= q_neg_reg ? -quo_reg : quo_reg;
                    hi_reg <= r_neg_reg ? -rem_reg : rem_reg;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, signed correction, divide-by-zero, abort and back-to-back runs.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    div_sequencer dut (
        .clock       (clk),
        .clear       (clear),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Edge 0 is the edge right before start is driven; start is accepted at edge 1.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dbz);
        int          first_done;
        int          busy_bad;
        logic [31:0] cap_lo, cap_hi;
        logic        cap_dbz;
        first_done = 0;
        busy_bad   = 0;
        cap_lo     = '0;
        cap_hi     = '0;
        cap_dbz    = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; signed_op = sgn; dividend = a; divisor = b;
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b0;
                dividend = $urandom;
                divisor = $urandom;
            end
            if (done && first_done == 0) first_done = k;
            if (k <= lat && !busy) busy_bad++;
            if (k == lat) begin
                cap_lo  = lo;
                cap_hi  = hi;
                cap_dbz = div_by_zero;
            end
            if (k == lat + 1) check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
        check({tag, "_done_edge"}, 32'(first_done), 32'(lat));
        check({tag, "_busy_gaps"}, 32'(busy_bad), 32'd0);
        check({tag, "_lo"}, cap_lo, exp_lo);
        check({tag, "_hi"}, cap_hi, exp_hi);
        check({tag, "_dbz"}, 32'(cap_dbz), 32'(exp_dbz));
    endtask

    initial begin
        int          seen_done;
        int          n_done;
        int          d1, d2;
        logic [31:0] lo1, hi1, lo2, hi2;

        clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 clear = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 35, 32'd14, 32'd2, 1'b0);
        do_div("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 35, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        do_div("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 35, 32'hFFFFFFF2, 32'd2, 1'b0);

        // Abort mid-iteration: clear asserted on edge 10.
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        do_div("u5_0", 1'b0, 32'd5, 32'd0, 2, 32'hFFFFFFFF, 32'd5, 1'b1);
        do_div("s5_0", 1'b1, 32'd5, 32'd0, 2, 32'hFFFFFFFF, 32'd5, 1'b1);
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 35, 32'd3, 32'd0, 1'b0);

        // Back-to-back with start held high; operands change after each accepting edge.
        n_done = 0; d1 = 0; d2 = 0; lo1 = '0; hi1 = '0; lo2 = '0; hi2 = '0;
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd20; divisor = 32'd6;
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                dividend = 32'hFFFFFFFF;
                divisor = 32'd1;
            end
            if (k == 37) begin
                start = 1'b0;
                dividend = 32'd12345;
                divisor = 32'd77;
            end
            if (done) begin
                if (n_done == 0) begin d1 = k; lo1 = lo; hi1 = hi; end
                else if (n_done == 1) begin d2 = k; lo2 = lo; hi2 = hi; end
                n_done++;
            end
        end
        check("b2b_n_done", 32'(n_done), 32'd2);
        check("b2b_done1_edge", 32'(d1), 32'd35);
        check("b2b_done2_edge", 32'(d2), 32'd71);
        check("b2b_lo1", lo1, 32'd3);
        check("b2b_hi1", hi1, 32'd2);
        check("b2b_lo2", lo2, 32'hFFFFFFFF);
        check("b2b_hi2", hi2, 32'd0);

        do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 35, 32'h80000000, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
